// File: rtl/fp_fixed_pkg.sv
// fp_fixed_pkg: shared constants, field positions and state encoding for the float/fixed converters.
package fp_fixed_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FIX_W = 65;
  localparam int FLT_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] BIAS = 8'd127;
  localparam logic signed [EXP_W-1:0] INT_BITS = 8'sd32;
  localparam int SIGN_POS = FLT_W - 1;
  localparam int EXP_MSB = FLT_W - 2;
  localparam int EXP_LSB = MAN_W;
  localparam int MAN_MSB = MAN_W - 1;
  typedef logic [2:0] state_t;
  localparam state_t ST_RST = 3'd0;
  localparam state_t ST_IDLE = 3'd1;
  localparam state_t ST_ZERO = 3'd2;
  localparam state_t ST_ABS = 3'd3;
  localparam state_t ST_NORM4 = 3'd4;
  localparam state_t ST_NORM1 = 3'd5;
  localparam state_t ST_ROUND = 3'd6;
  localparam state_t ST_DONE = 3'd7;
  function automatic logic [FLT_W-1:0] pack_float(input logic s, input logic [EXP_W-1:0] e,
                                                  input logic [MAN_W-1:0] m);
    logic [FLT_W-1:0] f;
    f = '0;
    f[SIGN_POS] = s;
    f[EXP_MSB:EXP_LSB] = e;
    f[MAN_MSB:0] = m;
    return f;
  endfunction
endpackage

// File: rtl/fixed_point_32_32_to_ieee_754_round_pack.sv
// fx2f_round_pack: rounds a normalised magnitude and packs the IEEE single result.
// Round-to-nearest-even when FX2F_ROUND_NEAREST_EN is defined, truncation otherwise.
module fx2f_round_pack
  import fp_fixed_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [63:0]      mag_i,
  output logic [FLT_W-1:0] float_o,
  output logic             inexact_o
);
  logic [MAN_W-1:0] man;
  logic guard, sticky, up;
  logic [MAN_W:0] man_r;
  assign man = mag_i[63:41];
  assign guard = mag_i[40];
  assign sticky = |mag_i[39:0];
`ifdef FX2F_ROUND_NEAREST_EN
  assign up = guard & (sticky | man[0]);
`else
  assign up = 1'b0;
`endif
  // A carry out of the mantissa leaves man_r[22:0] at zero and bumps the exponent.
  assign man_r = {1'b0, man} + {{MAN_W{1'b0}}, up};
  assign float_o = pack_float(sign_i, exp_i + BIAS + {{(EXP_W-1){1'b0}}, man_r[MAN_W]}, man_r[MAN_W-1:0]);
  assign inexact_o = guard | sticky;
endmodule

// File: rtl/fixed_point_32_32_to_ieee_754.sv
// fixed_point_32_32_to_ieee_754: multi-cycle Q33.32 to IEEE single converter using an iterative shift normaliser.
// Optional round-to-nearest-even via FX2F_ROUND_NEAREST_EN (truncation when undefined).
module fixed_point_32_32_to_ieee_754
  import fp_fixed_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [FIX_W-1:0] fixed_in,
  input  logic             start,
  output logic [FLT_W-1:0] float_out,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             inexact
);
  state_t state_q, state_d;
  logic [FIX_W-1:0] mag_q, mag_d;
  logic signed [EXP_W-1:0] exp_q, exp_d;
  logic sign_q, sign_d;
  logic [FLT_W-1:0] float_q, float_d, packed_f;
  logic done_q, done_d, zero_q, zero_d, inexact_q, inexact_d, packed_inexact;
  fx2f_round_pack u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .mag_i    (mag_q[63:0]),
    .float_o  (packed_f),
    .inexact_o(packed_inexact)
  );
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    exp_d = exp_q;
    sign_d = sign_q;
    float_d = float_q;
    done_d = 1'b0;
    zero_d = 1'b0;
    inexact_d = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_IDLE;
      ST_IDLE: if (start) begin
        sign_d = fixed_in[FIX_W-1];
        mag_d = fixed_in;
        exp_d = INT_BITS;
        if (fixed_in == '0) begin
          state_d = ST_ZERO;
          float_d = '0;
          done_d = 1'b1;
          zero_d = 1'b1;
        end else state_d = ST_ABS;
      end
      ST_ZERO: state_d = ST_IDLE;
      // -2^32 negates to itself as an unsigned 65-bit value with only bit 64 set.
      ST_ABS: begin
        mag_d = sign_q ? ~mag_q + 1'b1 : mag_q;
        state_d = ST_NORM4;
      end
      ST_NORM4: if (mag_q[64:61] == 4'd0) begin
        mag_d = mag_q << 4;
        exp_d = exp_q - 8'sd4;
      end else state_d = ST_NORM1;
      ST_NORM1: if (!mag_q[64]) begin
        mag_d = mag_q << 1;
        exp_d = exp_q - 8'sd1;
      end else state_d = ST_ROUND;
      ST_ROUND: begin
        float_d = packed_f;
        inexact_d = packed_inexact;
        done_d = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RST;
      mag_q <= '0;
      exp_q <= '0;
      sign_q <= 1'b0;
      float_q <= '0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      exp_q <= exp_d;
      sign_q <= sign_d;
      float_q <= float_d;
      done_q <= done_d;
      zero_q <= zero_d;
      inexact_q <= inexact_d;
    end
  end
  assign float_out = float_q;
  assign done = done_q;
  assign zero = zero_q;
  assign inexact = inexact_q;
  assign busy = (state_q != ST_IDLE) && (state_q != ST_RST);
endmodule

// File: tb/tb_fixed_point_32_32_to_ieee_754.sv
// tb_fixed_point_32_32_to_ieee_754: directed and random checks of the Q33.32 to float converter against an arithmetic model.
module tb_fixed_point_32_32_to_ieee_754;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [64:0] fixed_in = '0;
  logic [31:0] float_out;
  logic done, busy, zero, inexact;
  int checks = 0, errors = 0;
  fixed_point_32_32_to_ieee_754 dut (
    .clk(clk), .reset(reset), .fixed_in(fixed_in), .start(start),
    .float_out(float_out), .done(done), .busy(busy), .zero(zero), .inexact(inexact)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // Value = a * 2^-32; position p of the top set bit gives exponent p-32 and the 23 bits below it.
  function automatic void model(input logic [64:0] x, output logic [31:0] f, output logic inx, output int lat);
    logic [64:0] a, t;
    int p;
    logic g, s, up;
    logic [23:0] mr;
    f = '0; inx = 1'b0; lat = 1;
    if (x == '0) return;
    a = x[64] ? -x : x;
    p = 0;
    for (int i = 0; i < 65; i++) if (a[i]) p = i;
    t = (p >= 23) ? (a >> (p - 23)) : (a << (23 - p));
    g = (p >= 24) ? a[p-24] : 1'b0;
    s = (p >= 25) ? ((a & ((65'd1 << (p - 24)) - 65'd1)) != '0) : 1'b0;
`ifdef FX2F_ROUND_NEAREST_EN
    up = g & (s | t[0]);
`else
    up = 1'b0;
`endif
    mr = {1'b0, t[22:0]} + {23'd0, up};
    f = {x[64], 8'(p - 32 + 127 + int'(mr[23])), mr[22:0]};
    inx = g | s;
    lat = 5 + (64 - p) / 4 + (64 - p) % 4;
  endfunction
  task automatic convert(input logic [64:0] x, input logic [31:0] ef, input logic ei, input int el,
                         input string tag, input bit junk);
    int c;
    @(negedge clk); fixed_in = x; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    c = 1;
    while (!done && c < 40) begin
      if (junk && c == 2) begin fixed_in = ~x; start = 1'b1; end else start = 1'b0;
      @(posedge clk); #1; c++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(c), 64'(el));
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".float"}, 64'(float_out), 64'(ef));
    check({tag, ".inexact"}, 64'(inexact), 64'(ei));
    check({tag, ".zero"}, 64'(zero), 64'(x == '0));
    @(posedge clk); #1;
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".held"}, 64'(float_out), 64'(ef));
  endtask
  task automatic convert_model(input logic [64:0] x, input string tag, input bit junk);
    logic [31:0] ef; logic ei; int el;
    model(x, ef, ei, el);
    convert(x, ef, ei, el, tag, junk);
  endtask
  initial begin
    logic [95:0] w;
    logic [64:0] r;
    int dn;
    #12;
    check("rst.float", 64'(float_out), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.inexact", 64'(inexact), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    convert(65'h0_0000_0001_0000_0000, 32'h3F800000, 1'b0, 13, "one", 1'b0);
    convert(-65'h0_0000_0002_8000_0000, 32'hC0200000, 1'b0, 15, "m2p5", 1'b1);
    convert(65'h1_0000_0000_0000_0000, 32'hCF800000, 1'b0, 5, "min", 1'b0);
    convert(65'd0, 32'h00000000, 1'b0, 1, "zero", 1'b0);
    convert(65'd1, 32'h2F800000, 1'b0, 21, "lsb", 1'b1);
`ifdef FX2F_ROUND_NEAREST_EN
    convert(65'd16777219 << 32, 32'h4B800002, 1'b1, 7, "tie", 1'b0);
    convert(65'd33554431 << 32, 32'h4C000000, 1'b1, 7, "carry", 1'b0);
`else
    convert(65'd16777219 << 32, 32'h4B800001, 1'b1, 7, "tie", 1'b0);
    convert(65'd33554431 << 32, 32'h4BFFFFFF, 1'b1, 7, "carry", 1'b0);
`endif
    @(negedge clk); fixed_in = 65'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("abort.busy_abs", 64'(busy), 64'd1);
    @(posedge clk); #1; fixed_in = 65'h0_0000_0001_0000_0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("abort.busy_norm4", 64'(busy), 64'd1);
    @(negedge clk); reset = 1'b1; #1;
    check("abort.float", 64'(float_out), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.zero", 64'(zero), 64'd0);
    check("abort.inexact", 64'(inexact), 64'd0);
    @(negedge clk); reset = 1'b0;
    dn = 0;
    repeat (30) begin @(posedge clk); #1; dn += int'(done); end
    check("abort.no_done", 64'(dn), 64'd0);
    check("abort.idle", 64'(busy), 64'd0);
    convert_model(65'h0_0000_0000_0000_0003, "b2b0", 1'b0);
    convert_model(-65'h0_0000_1234_5678_9ABC, "b2b1", 1'b0);
    for (int i = 0; i < 200; i++) begin
      w = {$urandom, $urandom, $urandom};
      r = w[64:0] >> $urandom_range(0, 64);
      if ($urandom_range(0, 1) == 1) r = -r;
      convert_model(r, "rand", i % 7 == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
